// File: rtl/game_sequencer.sv
// Game-flow controller for the brick-breaker datapath: idle/serve/play/life-lost/game-over/win sequencing.
// Optional feature: define SCORE_EN to build the cleared-block score counter (otherwise score_o is tied to 0).
module game_sequencer #(
    parameter int NUM_BLOCKS  = 56,
    parameter int START_LIVES = 3,
    parameter int SERVE_TICKS = 60,
    parameter int PAUSE_TICKS = 120
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_btn_i,
    input  logic                  move_tick_i,
    input  logic [1:0]            lives_in_i,
    input  logic [NUM_BLOCKS-1:0] visible_i,
    output logic                  ball_run_o,
    output logic                  ball_reset_o,
    output logic                  new_game_o,
    output logic [2:0]            game_state_o,
    output logic [9:0]            score_o
);

    localparam int MAX_TICKS = (SERVE_TICKS > PAUSE_TICKS) ? SERVE_TICKS : PAUSE_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_LIFE_LOST = 3'd3,
        S_GAME_OVER = 3'd4,
        S_WIN       = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             armed_q, armed_d;
    logic [1:0]       prev_lives_q, prev_lives_d;
    logic             ball_run_q, ball_run_d;
    logic             ball_reset_q, ball_reset_d;
    logic             new_game_q, new_game_d;

    logic start_rise;
    logic start_game;
    logic life_lost;
    logic win;

    // A button already held when reset releases must fall before it can start a game.
    assign start_rise = start_btn_i & ~start_q & armed_q;
    assign armed_d    = armed_q | ~start_btn_i;
    assign life_lost  = (lives_in_i < prev_lives_q);
    assign win        = (visible_i == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_game   = 1'b0;
        ball_reset_d = 1'b0;
        case (state_q)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (start_rise) begin
                    state_d    = S_SERVE;
                    cnt_d      = '0;
                    start_game = 1'b1;
                end
            end
            S_SERVE: begin
                if (move_tick_i) begin
                    if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (win) begin
                    state_d = S_WIN;
                end else if (life_lost) begin
                    if (lives_in_i == 2'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        state_d = S_LIFE_LOST;
                        cnt_d   = '0;
                    end
                end
            end
            S_LIFE_LOST: begin
                if (move_tick_i) begin
                    if (cnt_q == CNT_W'(PAUSE_TICKS - 1)) begin
                        state_d      = S_SERVE;
                        cnt_d        = '0;
                        ball_reset_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (start_game) begin
            ball_reset_d = 1'b1;
        end
        new_game_d   = start_game;
        ball_run_d   = (state_d == S_PLAY);
        prev_lives_d = start_game ? 2'(START_LIVES) : lives_in_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            armed_q      <= 1'b0;
            prev_lives_q <= 2'(START_LIVES);
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            new_game_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_btn_i;
            armed_q      <= armed_d;
            prev_lives_q <= prev_lives_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            new_game_q   <= new_game_d;
        end
    end

    assign ball_run_o   = ball_run_q;
    assign ball_reset_o = ball_reset_q;
    assign new_game_o   = new_game_q;
    assign game_state_o = state_q;

`ifdef SCORE_EN
    localparam int PC_W = $clog2(NUM_BLOCKS + 1);

    logic [NUM_BLOCKS-1:0] prev_visible_q, prev_visible_d;
    logic [9:0]            score_q, score_d;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_BLOCKS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [PC_W-1:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + 11'(b);
        return sum[10] ? 10'h3FF : sum[9:0];
    endfunction

    always_comb begin
        score_d        = score_q;
        prev_visible_d = start_game ? '1 : visible_i;
        if (start_game) begin
            score_d = '0;
        end else if (state_q == S_PLAY) begin
            score_d = sat_add(score_q, popcount(prev_visible_q & ~visible_i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q        <= '0;
            prev_visible_q <= '1;
        end else begin
            score_q        <= score_d;
            prev_visible_q <= prev_visible_d;
        end
    end

    assign score_o = score_q;
`else
    assign score_o = '0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed game scenarios, a phase-level reference model
// compared every cycle, and literal expectations at the key scenario points.
module tb_game_sequencer;

    localparam int NB    = 56;
    localparam int SERVE = 60;
    localparam int PAUSE = 120;
`ifdef SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_btn;
    logic          move_tick;
    logic [1:0]    lives_in;
    logic [NB-1:0] visible;
    logic          ball_run;
    logic          ball_reset;
    logic          new_game;
    logic [2:0]    game_state;
    logic [9:0]    score;

    int checks = 0;
    int errors = 0;

    game_sequencer #(
        .NUM_BLOCKS (NB),
        .START_LIVES(3),
        .SERVE_TICKS(SERVE),
        .PAUSE_TICKS(PAUSE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn_i (start_btn),
        .move_tick_i (move_tick),
        .lives_in_i  (lives_in),
        .visible_i   (visible),
        .ball_run_o  (ball_run),
        .ball_reset_o(ball_reset),
        .new_game_o  (new_game),
        .game_state_o(game_state),
        .score_o     (score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: game phase, ticks spent in the phase, and the last observed lives/blocks.
    int            m_phase      = 0;
    int            m_ticks      = 0;
    int            m_prev_lives = 3;
    int            m_score      = 0;
    logic [NB-1:0] m_prev_vis   = '1;
    bit            m_last_btn   = 1'b0;
    bit            m_seen_low   = 1'b0;
    bit            m_breset     = 1'b0;
    bit            m_newg       = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase      = 0;
            m_ticks      = 0;
            m_prev_lives = 3;
            m_score      = 0;
            m_prev_vis   = '1;
            m_last_btn   = 1'b0;
            m_seen_low   = 1'b0;
            m_breset     = 1'b0;
            m_newg       = 1'b0;
        end else begin : model_step
            bit rise;
            bit fresh;
            int nxt;
            rise     = start_btn && !m_last_btn && m_seen_low;
            fresh    = 1'b0;
            m_breset = 1'b0;
            nxt      = m_phase;
            if ((m_phase == 0 || m_phase == 4 || m_phase == 5) && rise) begin
                fresh   = 1'b1;
                nxt     = 1;
                m_ticks = 0;
                m_score = 0;
            end else if (m_phase == 1 && move_tick) begin
                m_ticks++;
                if (m_ticks == SERVE) begin
                    nxt     = 2;
                    m_ticks = 0;
                end
            end else if (m_phase == 2) begin
                if (SC) begin
                    m_score = m_score + $countones(m_prev_vis & ~visible);
                    if (m_score > 1023) m_score = 1023;
                end
                if (visible == '0) begin
                    nxt = 5;
                end else if (int'(lives_in) < m_prev_lives) begin
                    nxt     = (lives_in == 2'd0) ? 4 : 3;
                    m_ticks = 0;
                end
            end else if (m_phase == 3 && move_tick) begin
                m_ticks++;
                if (m_ticks == PAUSE) begin
                    nxt      = 1;
                    m_ticks  = 0;
                    m_breset = 1'b1;
                end
            end
            m_newg = fresh;
            if (fresh) m_breset = 1'b1;
            m_prev_lives = fresh ? 3 : int'(lives_in);
            m_prev_vis   = fresh ? '1 : visible;
            m_seen_low   = m_seen_low | !start_btn;
            m_last_btn   = start_btn;
            m_phase      = nxt;
        end
    end

    always @(negedge clk) begin
        check("model_state", 32'(game_state), 32'(m_phase));
        check("model_run", 32'(ball_run), 32'(m_phase == 2));
        check("model_ball_reset", 32'(ball_reset), 32'(m_breset));
        check("model_new_game", 32'(new_game), 32'(m_newg));
        check("model_score", 32'(score), 32'(m_score));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        step();
    endtask

    task automatic serve();
        repeat (SERVE - 1) tick();
        check("serve_wait_state", 32'(game_state), 32'd1);
        move_tick = 1'b1;
        step();
        check("serve_done_state", 32'(game_state), 32'd2);
        check("serve_done_run", 32'(ball_run), 32'd1);
        move_tick = 1'b0;
        step();
    endtask

    logic [NB-1:0] half_mask;

    initial begin
        half_mask = {28{2'b10}};
        rst       = 1'b1;
        start_btn = 1'b0;
        move_tick = 1'b0;
        lives_in  = 2'd3;
        visible   = '1;
        repeat (3) step();
        check("reset_state", 32'(game_state), 32'd0);
        check("reset_score", 32'(score), 32'd0);
        rst = 1'b0;
        repeat (3) step();

        // New game from IDLE, then serve into play
        start_btn = 1'b1;
        step();
        check("t1_new_game", 32'(new_game), 32'd1);
        check("t1_ball_reset", 32'(ball_reset), 32'd1);
        check("t1_state", 32'(game_state), 32'd1);
        step();
        check("t1_new_game_end", 32'(new_game), 32'd0);
        check("t1_ball_reset_end", 32'(ball_reset), 32'd0);
        start_btn = 1'b0;
        serve();

        // Life lost, pause, re-serve
        lives_in = 2'd2;
        step();
        check("t2_state", 32'(game_state), 32'd3);
        check("t2_run", 32'(ball_run), 32'd0);
        repeat (PAUSE - 1) tick();
        check("t2_pause_wait", 32'(game_state), 32'd3);
        move_tick = 1'b1;
        step();
        check("t2_reserve_pulse", 32'(ball_reset), 32'd1);
        check("t2_reserve_state", 32'(game_state), 32'd1);
        move_tick = 1'b0;
        step();
        check("t2_pulse_end", 32'(ball_reset), 32'd0);
        lives_in = 2'd1;
        serve();

        // Score: 3 blocks then 1 block
        visible[2:0] = 3'b000;
        step();
        visible[5] = 1'b0;
        step();
        check("t5_score", 32'(score), SC ? 32'd4 : 32'd0);

        // Last life lost, then restart from GAME_OVER
        lives_in = 2'd0;
        step();
        check("t3_state", 32'(game_state), 32'd4);
        check("t3_run", 32'(ball_run), 32'd0);
        repeat (3) step();
        check("t3_score_hold", 32'(score), SC ? 32'd4 : 32'd0);
        start_btn = 1'b1;
        lives_in  = 2'd3;
        visible   = '1;
        step();
        check("t3_new_game", 32'(new_game), 32'd1);
        check("t3_restart_state", 32'(game_state), 32'd1);
        check("t3_score_clear", 32'(score), 32'd0);
        start_btn = 1'b0;
        lives_in  = 2'd2;
        serve();

        // Lives rising in play is not a loss
        lives_in = 2'd3;
        step();
        check("rise_ignored", 32'(game_state), 32'd2);

        // Score saturation: 37 drops of 28 blocks
        repeat (37) begin
            visible = half_mask;
            step();
            visible = '1;
            step();
        end
        check("score_saturate", 32'(score), SC ? 32'd1023 : 32'd0);

        // Win beats a simultaneous life loss
        visible  = '0;
        lives_in = 2'd2;
        step();
        check("t4_win", 32'(game_state), 32'd5);
        check("t4_run", 32'(ball_run), 32'd0);
        check("t4_score", 32'(score), SC ? 32'd1023 : 32'd0);

        // Restart from WIN, reach LIFE_LOST, reset mid-pause with button held
        step();
        visible   = '1;
        lives_in  = 2'd3;
        start_btn = 1'b1;
        step();
        check("t6_start_from_win", 32'(game_state), 32'd1);
        serve();
        lives_in = 2'd2;
        step();
        check("t6_life_lost", 32'(game_state), 32'd3);
        repeat (30) tick();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(game_state), 32'd0);
        check("t6_rst_run", 32'(ball_run), 32'd0);
        check("t6_rst_ball_reset", 32'(ball_reset), 32'd0);
        check("t6_rst_new_game", 32'(new_game), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        repeat (5) begin
            step();
            check("t6_held_state", 32'(game_state), 32'd0);
            check("t6_held_new_game", 32'(new_game), 32'd0);
        end
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        check("t6_restart_state", 32'(game_state), 32'd1);
        check("t6_restart_new_game", 32'(new_game), 32'd1);
        start_btn = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
